// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// fwd_hazard_unit : in-flight destination tracker driving EX bypass selects
//                   and the ID load-use stall.          Revision 1.0
// ============================================================================
module fwd_hazard_unit #(
  parameter  int REG_W      = 5,
  parameter  int NSRC       = 2,
  parameter  int DEPTH      = 2,
  parameter  int LOAD_STAGE = 2,
  localparam int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  issue_valid_i,
  input  logic [REG_W-1:0]      issue_rd_i,
  input  logic                  issue_write_i,
  input  logic                  issue_load_i,
  input  logic [NSRC*REG_W-1:0] id_src_i,
  input  logic [NSRC*REG_W-1:0] ex_src_i,
  input  logic                  flush_i,
  input  logic                  stall_ext_i,
  output logic [NSRC*SEL_W-1:0] fwd_sel_o,
  output logic                  hazard_stall_o,
  output logic [15:0]           stall_cnt_o,
  output logic                  fwd_err_o
);

  logic [DEPTH:0]   valid_q, valid_d;
  logic [DEPTH:0]   write_q, write_d;
  logic [DEPTH:0]   load_q,  load_d;
  logic [REG_W-1:0] rd_q [DEPTH+1];
  logic [REG_W-1:0] rd_d [DEPTH+1];
  logic [15:0]      cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [DEPTH:0]   live;
  logic [REG_W-1:0] op_src;
  logic [SEL_W-1:0] op_sel;
  logic             op_early;
  logic             early_hit;

  for (genvar p = 0; p <= DEPTH; p++) begin : g_live
    assign live[p] = valid_q[p] & write_q[p] & (rd_q[p] != '0);
  end

  always_comb begin
    fwd_sel_o = '0;
    early_hit = 1'b0;
    op_src    = '0;
    op_sel    = '0;
    op_early  = 1'b0;
    for (int j = 0; j < NSRC; j++) begin
      op_src   = ex_src_i[j*REG_W +: REG_W];
      op_sel   = '0;
      op_early = 1'b0;
      // Oldest to youngest, so the youngest matching stage is the one kept.
      for (int k = DEPTH; k >= 1; k--) begin
        if (live[k] && (rd_q[k] == op_src)) begin
          op_early = load_q[k] && (k < LOAD_STAGE);
          op_sel   = op_early ? '0 : SEL_W'(k);
        end
      end
      fwd_sel_o[j*SEL_W +: SEL_W] = op_sel;
      early_hit = early_hit | op_early;
    end
  end

  always_comb begin
    hazard_stall_o = 1'b0;
    for (int j = 0; j < NSRC; j++) begin
      for (int p = 0; p < LOAD_STAGE - 1; p++) begin
        if (live[p] && load_q[p] && (rd_q[p] == id_src_i[j*REG_W +: REG_W])) begin
          hazard_stall_o = 1'b1;
        end
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    write_d = write_q;
    load_d  = load_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    err_d   = err_q | early_hit;
    if (!stall_ext_i) begin
      // A stalled or flushed issue enters EX as a bubble.
      valid_d = {valid_q[DEPTH-1:0], issue_valid_i & ~flush_i & ~hazard_stall_o};
      write_d = {write_q[DEPTH-1:0], issue_write_i};
      load_d  = {load_q[DEPTH-1:0],  issue_load_i};
      for (int k = DEPTH; k >= 1; k--) begin
        rd_d[k] = rd_q[k-1];
      end
      rd_d[0] = issue_rd_i;
      if (hazard_stall_o && (cnt_q != 16'hFFFF)) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      write_q <= '0;
      load_q  <= '0;
      for (int p = 0; p <= DEPTH; p++) begin
        rd_q[p] <= '0;
      end
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      write_q <= write_d;
      load_q  <= load_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign stall_cnt_o = cnt_q;
  assign fwd_err_o   = err_q;

endmodule
`default_nettype wire

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the pipelined CPU. It keeps its own in-flight record of destination registers, one entry per pipeline position from EX down to the last forwarding stage. From that record it produces per-operand bypass selects for the instruction in EX and a load-use stall for the instruction in ID. It supports any register-index width, operand count, forwarding depth and load-data stage, and counts the hazard stalls it raises.

## Interface
- REG_W, 5, register index width
- NSRC, 2, source operands per instruction
- DEPTH, 2, forwarding stages after EX (stage 1 = EX/MEM, stage 2 = MEM/WB, …); legal range 1..7
- LOAD_STAGE, 2, first stage whose entry holds load data; legal range 1..DEPTH
- SEL_W, derived, clog2(DEPTH+1)
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous reset, active-low
- issue_valid_i  input  1  an instruction enters EX at the next edge
- issue_rd_i  input  REG_W  its destination register
- issue_write_i  input  1  it writes the register file
- issue_load_i  input  1  it is a load
- id_src_i  input  NSRC*REG_W  sources of the instruction in ID; operand j occupies bits [j*REG_W +: REG_W]
- ex_src_i  input  NSRC*REG_W  sources of the instruction in EX, same packing
- flush_i  input  1  kill the instruction entering EX
- stall_ext_i  input  1  whole pipeline frozen (memory wait)
- fwd_sel_o  output  NSRC*SEL_W  per-operand select; 0 = register file, k = stage k result
- hazard_stall_o  output  1  hold PC and IF/ID this cycle
- stall_cnt_o  output  16  hazard-stall cycles, saturating
- fwd_err_o  output  1  sticky; an EX operand matched a load whose data was not yet available

## Operation
- Tracker: entries P0 (EX) through PDEPTH. Each entry holds {valid, write, load, rd}.
- Live entry: valid && write && rd != 0.
- Forwarding, per operand j:
  - Scan k = 1..DEPTH, youngest first.
  - First live Pk with rd == ex_src j sets fwd_sel = k.
  - If that entry is a load and k < LOAD_STAGE: fwd_sel = 0 and fwd_err_o is set at the next edge.
  - No match: fwd_sel = 0.
- Load-use hazard:
  - hazard_stall_o = 1 when, for any ID operand, some live load entry at position p with p+1 < LOAD_STAGE has rd == that operand.
  - Only p = 0..LOAD_STAGE-2 is examined. With LOAD_STAGE = 1 the hazard never fires.
- Register 0 never matches, on either side.
- Edge update, in priority order:
  1. stall_ext_i = 1: all entries hold. stall_cnt_o does not increment.
  2. Otherwise, shift: Pk <= Pk-1 for k = DEPTH down to 1.
  3. P0 <= {issue_valid_i, issue_write_i, issue_load_i, issue_rd_i}, except P0 valid is forced to 0 when flush_i or hazard_stall_o is 1 (bubble insertion).
- PDEPTH's old contents fall off the end.
- stall_cnt_o increments on every edge where hazard_stall_o = 1 and stall_ext_i = 0. It saturates at 16'hFFFF.
- fwd_err_o clears only on reset.

## Timing
- fwd_sel_o and hazard_stall_o are combinational from registered entries plus id_src_i/ex_src_i. Valid in the same cycle; no added latency.
- The tracker changes only at rising clk_i edges.
- A destination issued at edge t is in P0 during cycle t, and in stage k during cycle t+k, provided there are no stall_ext_i cycles.
- Reset (rst_i low, any time, including mid-stall):
  - all entries invalid at once;
  - fwd_sel_o = 0, hazard_stall_o = 0, stall_cnt_o = 0, fwd_err_o = 0;
  - the first update occurs at the first rising edge after rst_i goes high.
- Simultaneous flush_i and hazard_stall_o: one bubble; the counter still increments.
- stall_ext_i together with hazard_stall_o: no bubble, no shift, no count. The stall persists into the next cycle.
- Equal rd in two stages: the lower k wins.

## Test plan
- Defaults. Issue write r3 (non-load). Next cycle ex_src op0 = 3 → fwd_sel op0 = 1. One cycle later → 2. One cycle after that → 0.
- Defaults. Issue load r5, then ID src op1 = 5 → hazard_stall_o = 1 for exactly one cycle, and P0 becomes a bubble. The next cycle gives EX fwd_sel op1 = 2, stall_cnt_o = 1, fwd_err_o = 0.
- Issue write r0 followed by a source of 0 → no forward and no stall. Back-to-back writes to r7, then src 7 → select 1, not 2.
- DEPTH = 4, LOAD_STAGE = 3, load r9 followed by a dependent in ID → two consecutive stall cycles, then fwd_sel = 3. stall_ext_i high for 3 cycles mid-sequence → entries frozen, counter unchanged.
- flush_i asserted with issue of write r4 → no later match on 4 in any stage.
- Assert rst_i low while a load-use stall is active → all outputs 0 immediately. After release, src 5 produces no stall.
